// File: rtl/reg_shift_sequencer_pkg.sv
// Shared constants for the register-specified shift sequencer: shift types,
// FSM state encoding and the operand-2 field positions it decodes.
package reg_shift_sequencer_pkg;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_RS = 2'd1,
        ISSUE   = 2'd2
    } seq_state_t;

    localparam int RS_HI   = 11;
    localparam int RS_LO   = 8;
    localparam int TYPE_HI = 6;
    localparam int TYPE_LO = 5;
    localparam int BIT7    = 7;
    localparam int BIT4    = 4;

endpackage

// File: rtl/reg_shift_amt_resolve.sv
// Turns an 8-bit register shift amount and shift type into the immediate-style
// 5-bit amount plus the saturation flags the operand-2 shifter understands.
module reg_shift_amt_resolve
    import reg_shift_sequencer_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] i_amt,
    input  logic [1:0]       i_shift_type,
    output logic [4:0]       o_shift_amt,
    output logic             o_force_zero,
    output logic             o_force_sign,
    output logic             o_bypass
);

    logic w_big;

    // Any bit above bit 4 means the amount is 32 or more.
    assign w_big = |(i_amt >> 5);

    always_comb begin
        o_shift_amt  = '0;
        o_force_zero = 1'b0;
        o_force_sign = 1'b0;
        o_bypass     = 1'b0;
        if (i_amt == '0) begin
            o_bypass = 1'b1;
        end else begin
            case (i_shift_type)
                ROR: begin
                    if (i_amt[4:0] == 5'd0) o_bypass    = 1'b1;
                    else                    o_shift_amt = i_amt[4:0];
                end
                ASR: begin
                    if (w_big) o_force_sign = 1'b1;
                    else       o_shift_amt  = i_amt[4:0];
                end
                default: begin
                    if (w_big) o_force_zero = 1'b1;
                    else       o_shift_amt  = i_amt[4:0];
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_shift_sequencer.sv
// Stalls IF/ID for two cycles on a register-specified shift, borrows RF read
// port 2 to fetch Rs, then presents a resolved amount on the issue cycle.
module reg_shift_sequencer
    import reg_shift_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              imm,
    input  logic              mem_instr,
    input  logic [11:0]       shift_operand,
    input  logic              hazard_stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] rs_data,
    output logic              rf2_sel_rs,
    output logic [3:0]        rf2_addr_rs,
    output logic              seq_stall,
    output logic              rs_shift,
    output logic [4:0]        shift_amt,
    output logic [1:0]        shift_type,
    output logic              force_zero,
    output logic              force_sign,
    output logic              bypass,
    output logic [1:0]        dbg_state
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [AMT_W-1:0] r_amt;
    logic [1:0]       r_type;

    logic       w_start;
    logic       w_stall;
    logic       w_sel_rs;
    logic       w_issue;
    logic       w_ld_type;
    logic       w_ld_amt;
    logic [4:0] w_res_amt;
    logic       w_res_zero;
    logic       w_res_sign;
    logic       w_res_bypass;
    logic       w_unused;

    assign w_unused = ^{1'b0, rs_data[DATA_W-1:AMT_W], shift_operand[3:0]};

    // Bit7=1 with bit4=1 is a multiply/extension encoding, not a shift.
    assign w_start = id_valid & ~imm & ~mem_instr & shift_operand[BIT4]
                   & ~shift_operand[BIT7] & ~hazard_stall & ~flush;

    // seq_stall freezes PC and IF/ID while high; the ID instruction advances
    // into ID/EX only on a cycle where seq_stall and hazard_stall are both low.
    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_sel_rs  = 1'b0;
        w_issue   = 1'b0;
        w_ld_type = 1'b0;
        w_ld_amt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_start;
                if (w_start) begin
                    w_ld_type = 1'b1;
                    w_next    = READ_RS;
                end
            end
            READ_RS: begin
                w_stall  = 1'b1;
                w_sel_rs = 1'b1;
                if (flush) begin
                    w_next = IDLE;
                end else begin
                    w_ld_amt = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: begin
                w_issue = 1'b1;
                if (flush || !hazard_stall) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_amt   <= '0;
            r_type  <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_type) r_type <= shift_operand[TYPE_HI:TYPE_LO];
            if (w_ld_amt)  r_amt  <= rs_data[AMT_W-1:0];
        end
    end

    reg_shift_amt_resolve #(
        .AMT_W (AMT_W)
    ) u_resolve (
        .i_amt        (r_amt),
        .i_shift_type (r_type),
        .o_shift_amt  (w_res_amt),
        .o_force_zero (w_res_zero),
        .o_force_sign (w_res_sign),
        .o_bypass     (w_res_bypass)
    );

    assign seq_stall   = w_stall;
    assign rf2_sel_rs  = w_sel_rs;
    assign rf2_addr_rs = w_sel_rs ? shift_operand[RS_HI:RS_LO] : 4'd0;
    assign rs_shift    = w_issue;
    assign shift_amt   = w_issue ? w_res_amt : 5'd0;
    assign force_zero  = w_issue & w_res_zero;
    assign force_sign  = w_issue & w_res_sign;
    assign bypass      = w_issue & w_res_bypass;
    assign shift_type  = r_type;
    assign dbg_state   = r_state;

endmodule
